// File: rtl/hwpe_ctrl_uloop_issuer_if.sv
// Bundle of the two handshakes around the uloop issuer:
//   - uloop side: clear/enable out, flags/offsets/indices back in
//   - streamer side: captured set presented over valid/ready
// The master modport is the issuer's view; the slave modport is the
// view of whatever sits on the other side (uloop engine plus streamers).
interface hwpe_ctrl_uloop_issuer_if #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
);

  // uloop control/flags
  logic                            uloop_clear;
  logic                            uloop_enable;
  logic                            uloop_valid;
  logic                            uloop_ready;
  logic                            uloop_done;
  logic [NB_REG*REG_WIDTH-1:0]     uloop_offs;
  logic [NB_LOOPS*CNT_WIDTH-1:0]   uloop_idx;

  // captured set towards the streamer address generators
  logic                            out_valid;
  logic                            out_ready;
  logic [NB_REG*REG_WIDTH-1:0]     out_offs;
  logic [NB_LOOPS*CNT_WIDTH-1:0]   out_idx;
  logic                            out_last;

  modport master (
    output uloop_clear, uloop_enable,
    input  uloop_valid, uloop_ready, uloop_done, uloop_offs, uloop_idx,
    output out_valid, out_offs, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  uloop_clear, uloop_enable,
    output uloop_valid, uloop_ready, uloop_done, uloop_offs, uloop_idx,
    input  out_valid, out_offs, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/hwpe_ctrl_uloop_issuer.sv
// Initiator side of the uloop control interface.
// Sequence per job: clear the uloop once, then repeatedly request a step
// (enable), capture the returned offset/index set, hand it to the
// streamers, and finish when the uloop flags done on a set.
// Optional watchdog on the wait for uloop flags, enabled by defining
// HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN (TIMEOUT cycles, sticky error_o).
module hwpe_ctrl_uloop_issuer #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] iter_cnt_o,
  hwpe_ctrl_uloop_issuer_if.master bus
);

  localparam int unsigned OFFS_W = NB_REG * REG_WIDTH;
  localparam int unsigned IDX_W  = NB_LOOPS * CNT_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                in_job;
  logic                kill;
  logic                start_take;
  logic                clear_pulse;
  logic                enable_pulse;
  logic                capture;
  logic                handshake;
  logic                done_pulse;

  logic [OFFS_W-1:0]   offs_q;
  logic [IDX_W-1:0]    idx_q;
  logic                last_q;
  logic [31:0]         iter_q;

  assign in_job     = (state_q != ST_IDLE);
  // Abort only means something once a job is running; in IDLE it is dropped.
  assign kill       = abort_i && in_job;
  assign start_take = (state_q == ST_IDLE) && start_i;

`ifdef HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN
  localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             expire;
  logic             error_q;

  // tmo_q counts WAIT cycles already spent, so the TIMEOUT-th WAIT cycle
  // is the one that sees tmo_q == TIMEOUT-1.
  assign tmo_hit = (tmo_q == TMO_LAST);
`endif

  // Next-state and single-cycle control pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    state_d      = state_q;
    clear_pulse  = 1'b0;
    enable_pulse = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    done_pulse   = 1'b0;
`ifdef HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN
    expire       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clear_pulse = 1'b1;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (bus.uloop_ready) begin
          enable_pulse = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A valid arriving on the expiry cycle still counts as a normal set.
        if (bus.uloop_valid) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
`ifdef HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN
        else if (tmo_hit) begin
          expire      = 1'b1;
          clear_pulse = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          handshake = 1'b1;
          state_d   = last_q ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything: park the uloop with a clear and suppress
    // any step, capture, handshake or completion in this cycle.
    if (kill) begin
      state_d      = ST_IDLE;
      clear_pulse  = 1'b1;
      enable_pulse = 1'b0;
      capture      = 1'b0;
      handshake    = 1'b0;
      done_pulse   = 1'b0;
`ifdef HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN
      expire       = 1'b0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Captured set: loaded only on the valid cycle in WAIT, held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the wide data registers are reset too, so the streamer-facing
    // bus reads as zero out of reset rather than as stale/unknown data.
    if (rst_i) begin
      offs_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (capture) begin
      offs_q <= bus.uloop_offs;
      idx_q  <= bus.uloop_idx;
      last_q <= bus.uloop_done;
    end
  end

  // Delivered-set counter: zeroed by a new job, saturating, frozen on abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iter_q <= '0;
    end else if (start_take) begin
      iter_q <= '0;
    end else if (handshake && (iter_q != '1)) begin
      iter_q <= iter_q + 32'd1;
    end
  end

`ifdef HWPE_CTRL_ULOOP_ISSUER_TIMEOUT_EN
  // WAIT watchdog: restarts from zero every time WAIT is entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   tmo_q <= '0;
    else if (state_q == ST_WAIT) tmo_q <= tmo_q + TMO_W'(1);
    else                         tmo_q <= '0;
  end

  // Sticky error flag: set on expiry, cleared by the next accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           error_q <= 1'b0;
    else if (start_take) error_q <= 1'b0;
    else if (expire)     error_q <= 1'b1;
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign busy_o           = in_job;
  assign done_o           = done_pulse;
  assign iter_cnt_o       = iter_q;

  assign bus.uloop_clear  = clear_pulse;
  assign bus.uloop_enable = enable_pulse;
  assign bus.out_valid    = (state_q == ST_OUT) && !abort_i;
  assign bus.out_offs     = offs_q;
  assign bus.out_idx      = idx_q;
  assign bus.out_last     = last_q;

endmodule
